snake_move_scheduler: RTL and testbench
=======================================

SNAKE_MOVE_SCHEDULER -- requirements
Module: snake_move_scheduler

Interface
REQ-001 SHALL have parameter BASE_PERIOD, default 67108864, Clk cycles per move at Length 0.
REQ-002 SHALL have parameter SPEED_STEP, default 4194304, period reduction per unit of Length.
REQ-003 SHALL have parameter MIN_PERIOD, default 8388608, floor on move period (MIN_PERIOD >= 2).
REQ-004 Clk  in  1  single system clock; all logic on rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 Left, Right, Up, Down  in  1 each  single-cycle debounced press pulses.
REQ-007 Run  in  1  level; high while game is in play.
REQ-008 Length  in  4  current snake length, unsigned.
REQ-009 Tick  out  1  one-cycle move strobe to game core.
REQ-010 Dir  out  2  applied direction: 00 up, 01 right, 10 down, 11 left.
REQ-011 Queue_Level  out  2  pending direction count, 0..2.
REQ-012 Drop  out  1  one-cycle pulse, press rejected.

Function
REQ-013 Period SHALL be BASE_PERIOD - Length*SPEED_STEP, computed wide enough to detect underflow; underflow or result < MIN_PERIOD gives MIN_PERIOD.
REQ-014 States IDLE and RUN; IDLE->RUN on the cycle Run is sampled high, RUN->IDLE on the cycle Run is sampled low.
REQ-015 In IDLE: counter held 0, Tick 0, queue flushed, presses ignored without Drop, Dir retained.
REQ-016 In RUN: counter increments each cycle; when counter >= period-1, counter returns to 0 and Tick is asserted on the next cycle.
REQ-017 Comparison SHALL use >= so a mid-count Length increase that shortens period ends the current interval immediately.
REQ-018 First Tick SHALL occur exactly period cycles after the IDLE->RUN transition cycle.
REQ-019 On the cycle Tick is asserted, a non-empty queue head SHALL be popped and Dir SHALL show it on that same cycle; empty queue leaves Dir unchanged.
REQ-020 Multiple presses in one cycle: priority Up > Right > Down > Left; lower-priority presses are discarded and Drop pulses.
REQ-021 Reference direction for a press = queue tail if queue non-empty after any same-cycle pop consideration, else Dir.
REQ-022 Press SHALL be rejected (Drop) if equal to reference, opposite to reference (code XOR 10), or queue full after same-cycle pop.
REQ-023 Simultaneous pop and accepted push SHALL both occur; full queue plus Tick-pop accepts the push, Level stays 2.
REQ-024 Drop SHALL be registered: pulses the cycle after the rejected press.
REQ-025 Queue_Level SHALL reflect the registered queue occupancy, never exceeding 2.

Reset
REQ-026 Reset SHALL dominate Run and presses: state IDLE, counter 0, queue empty, Tick 0, Drop 0, Queue_Level 0, Dir 01.
REQ-027 Reset asserted mid-interval or mid-push SHALL discard all pending work; no Tick on the cycle after release.

Structure
REQ-028 Direction codes, opposite-direction function and state encoding SHALL live in shared package snake_pkg.
REQ-029 The two-entry queue SHALL be sub-module snake_dir_fifo (push, pop, head, tail, level, flush); period math and FSM in top.

Verification (BASE_PERIOD=20, SPEED_STEP=2, MIN_PERIOD=4)
REQ-030 Reset, Run=1, Length=0 -> Tick at cycles 20, 40, 60 after Run rise, Dir=01, Level=0.
REQ-031 Length=15 -> Tick every 4 cycles (underflow clamped); Length 0->8 at counter=10 -> Tick next cycle (period 4).
REQ-032 Dir=01, press Up then Left between ticks -> Level 2; next Tick Dir=00, Level 1; following Tick Dir=11, Level 0.
REQ-033 Dir=01, empty queue, press Left -> Drop one cycle later, Level 0; Up and Down same cycle -> Up queued, Drop pulses.
REQ-034 Queue holds Up, Left; press Down -> Drop, Level 2; press Down on Tick cycle -> accepted, Dir=00, Level 2.
REQ-035 Level 2, drop Run -> next cycle Level 0, no further Tick; Reset at counter 12 -> Dir=01, first Tick 20 cycles after Run re-entry.

Source files
------------

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction codes, FSM states and helpers for the snake move scheduler
//
// Purpose: direction encoding, state encoding, queue depth and the
// opposite-direction helper shared by snake_move_scheduler and snake_dir_fifo.
// Ports: none (package).
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned QUEUE_DEPTH = 2;

  // Opposite direction differs only in the upper code bit.
  function automatic logic [1:0] dir_opposite(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/snake_dir_fifo.sv
// rtl/snake_dir_fifo.sv - two-entry direction queue with simultaneous push/pop and flush
//
// Purpose: holds pending direction changes. Entry 0 is the head; entry 1 is
// only valid at level 2. Pop and push in the same cycle are both honoured,
// including when the queue is full.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   flush_i      empties the queue (takes priority over push/pop)
//   push_i       append push_data_i at the tail
//   push_data_i  direction code to append
//   pop_i        remove the head (ignored when empty)
//   head_o       oldest entry
//   tail_o       newest entry
//   level_o      registered occupancy, 0..2
module snake_dir_fifo
  import snake_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic [1:0] push_data_i,
  input  logic       pop_i,
  output logic [1:0] head_o,
  output logic [1:0] tail_o,
  output logic [1:0] level_o
);

  localparam logic [1:0] LEVEL_FULL = 2'(QUEUE_DEPTH);

  logic [1:0] mem0_q, mem0_d;
  logic [1:0] mem1_q, mem1_d;
  logic [1:0] level_q, level_d;

  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    level_d = level_q;
    if (flush_i) begin
      level_d = 2'd0;
    end else begin
      case (level_q)
        2'd0: begin
          if (push_i) begin
            mem0_d  = push_data_i;
            level_d = 2'd1;
          end
        end
        2'd1: begin
          if (push_i && pop_i) begin
            mem0_d = push_data_i;
          end else if (push_i) begin
            mem1_d  = push_data_i;
            level_d = LEVEL_FULL;
          end else if (pop_i) begin
            level_d = 2'd0;
          end
        end
        default: begin
          // Full: a push is only possible alongside a pop (shift and refill).
          if (pop_i) begin
            mem0_d = mem1_q;
            if (push_i) begin
              mem1_d = push_data_i;
            end else begin
              level_d = 2'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem0_q  <= 2'd0;
      mem1_q  <= 2'd0;
      level_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      level_q <= level_d;
    end
  end

  assign head_o  = mem0_q;
  assign tail_o  = (level_q == LEVEL_FULL) ? mem1_q : mem0_q;
  assign level_o = level_q;

endmodule

// File: rtl/snake_move_scheduler.sv
// rtl/snake_move_scheduler.sv - length-dependent move timer with buffered direction input
//
// Purpose: generates the move strobe at a period that shrinks with snake
// length, and queues up to two validated direction presses that are applied
// one per move.
// Ports:
//   Clk          clock, rising edge
//   Reset        synchronous active-high reset
//   Left/Right/Up/Down  single-cycle press pulses
//   Run          level, game in play
//   Length       current snake length
//   Tick         one-cycle move strobe
//   Dir          applied direction (00 up, 01 right, 10 down, 11 left)
//   Queue_Level  pending direction count
//   Drop         one-cycle pulse, the cycle after a rejected press
module snake_move_scheduler
  import snake_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 67108864,
  parameter int unsigned SPEED_STEP  = 4194304,
  parameter int unsigned MIN_PERIOD  = 8388608
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Left,
  input  logic       Right,
  input  logic       Up,
  input  logic       Down,
  input  logic       Run,
  input  logic [3:0] Length,
  output logic       Tick,
  output logic [1:0] Dir,
  output logic [1:0] Queue_Level,
  output logic       Drop
);

  // Wide enough for BASE_PERIOD and 15*SPEED_STEP; the extra diff bit is the borrow.
  localparam int PW = 36;

  logic [PW-1:0] prod_w, period_w;
  logic [PW:0]   diff_w;

  assign prod_w   = PW'(Length) * PW'(SPEED_STEP);
  assign diff_w   = {1'b0, PW'(BASE_PERIOD)} - {1'b0, prod_w};
  assign period_w = (diff_w[PW] || (diff_w[PW-1:0] < PW'(MIN_PERIOD)))
                    ? PW'(MIN_PERIOD) : diff_w[PW-1:0];

  state_e        state_q;
  logic [PW-1:0] cnt_q;
  logic          tick_q, drop_q;
  logic [1:0]    dir_q;

  logic       active, wrap, pop, any_press, multi_press, full_after_pop, accept, drop_d;
  logic [1:0] sel_dir, ref_dir, head, tail, level;
  logic [2:0] n_press;

  // Run going low is acted on in the same cycle it is sampled.
  assign active  = (state_q == ST_RUN) && Run;
  // >= lets a shortened period end the current interval at once.
  assign wrap    = active && (cnt_q >= (period_w - PW'(1)));
  assign pop     = wrap && (level != 2'd0);

  assign n_press     = 3'(Up) + 3'(Right) + 3'(Down) + 3'(Left);
  assign any_press   = (n_press != 3'd0);
  assign multi_press = (n_press > 3'd1);

  always_comb begin
    sel_dir = DIR_LEFT;
    if (Up)         sel_dir = DIR_UP;
    else if (Right) sel_dir = DIR_RIGHT;
    else if (Down)  sel_dir = DIR_DOWN;
    // With entries queued the tail is the reference; after a same-cycle pop
    // of the last entry that tail is also the new Dir.
    ref_dir        = (level != 2'd0) ? tail : dir_q;
    full_after_pop = (level == 2'(QUEUE_DEPTH)) && !pop;
    accept         = active && any_press && (sel_dir != ref_dir) &&
                     (sel_dir != dir_opposite(ref_dir)) && !full_after_pop;
    drop_d         = active && any_press && (!accept || multi_press);
  end

  snake_dir_fifo u_fifo (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .flush_i     (!active),
    .push_i      (accept),
    .push_data_i (sel_dir),
    .pop_i       (pop),
    .head_o      (head),
    .tail_o      (tail),
    .level_o     (level)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      drop_q  <= 1'b0;
      dir_q   <= DIR_RIGHT;
    end else begin
      tick_q <= wrap;
      drop_q <= drop_d;
      if (pop) dir_q <= head;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (Run) state_q <= ST_RUN;
        end
        default: begin
          if (!Run) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (wrap) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + PW'(1);
          end
        end
      endcase
    end
  end

  assign Tick        = tick_q;
  assign Dir         = dir_q;
  assign Queue_Level = level;
  assign Drop        = drop_q;

endmodule

// File: tb/tb_snake_move_scheduler.sv
// tb/tb_snake_move_scheduler.sv - scoreboard bench for snake_move_scheduler
module tb_snake_move_scheduler;

  localparam int BP = 20;
  localparam int SS = 2;
  localparam int MP = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Left = 1'b0, Right = 1'b0, Up = 1'b0, Down = 1'b0;
  logic       Run = 1'b0;
  logic [3:0] Length = 4'd0;
  logic       Tick;
  logic [1:0] Dir;
  logic [1:0] Queue_Level;
  logic       Drop;

  always #5 Clk = ~Clk;

  snake_move_scheduler #(
    .BASE_PERIOD (BP),
    .SPEED_STEP  (SS),
    .MIN_PERIOD  (MP)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Left        (Left),
    .Right       (Right),
    .Up          (Up),
    .Down        (Down),
    .Run         (Run),
    .Length      (Length),
    .Tick        (Tick),
    .Dir         (Dir),
    .Queue_Level (Queue_Level),
    .Drop        (Drop)
  );

  typedef struct packed {
    logic       tick;
    logic [1:0] dir;
    logic [1:0] level;
    logic       drop;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: game running flag, cycles elapsed in the current move
  // interval, list of pending directions, applied direction.
  bit         m_run = 1'b0;
  int         m_elapsed = 0;
  logic [1:0] m_pending[$];
  logic [1:0] m_dir = 2'b01;

  bit g_run = 1'b0;
  int g_len = 0;

  function automatic int period_of(input int len);
    int p;
    p = BP - len * SS;
    if (p < MP) p = MP;
    return p;
  endfunction

  task automatic step(input bit rst, input bit run, input int len,
                      input bit u, input bit r, input bit d, input bit l);
    exp_t       e;
    bit         t, dr, acc;
    int         n;
    logic [1:0] sel, refd;
    @(negedge Clk);
    Reset = rst; Run = run; Length = 4'(len);
    Up = u; Right = r; Down = d; Left = l;
    t = 1'b0; dr = 1'b0;
    if (rst) begin
      m_run = 1'b0; m_elapsed = 0; m_pending.delete(); m_dir = 2'b01;
    end else if (!m_run || !run) begin
      m_run = run && !m_run;
      m_elapsed = 0;
      m_pending.delete();
    end else begin
      // A move is due once the interval has lasted a full period.
      t = (m_elapsed + 1 >= period_of(len));
      m_elapsed = t ? 0 : m_elapsed + 1;
      if (t && m_pending.size() > 0) m_dir = m_pending.pop_front();
      n = int'(u) + int'(r) + int'(d) + int'(l);
      if (n > 0) begin
        sel  = u ? 2'b00 : r ? 2'b01 : d ? 2'b10 : 2'b11;
        refd = (m_pending.size() > 0) ? m_pending[$] : m_dir;
        acc  = (sel != refd) && (sel != (refd ^ 2'b10)) && (m_pending.size() < 2);
        if (acc) m_pending.push_back(sel);
        dr = !acc || (n > 1);
      end
    end
    e.tick  = t;
    e.dir   = m_dir;
    e.level = 2'(m_pending.size());
    e.drop  = dr;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, g_run, g_len, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rst_cycles(input int n);
    repeat (n) step(1'b1, g_run, g_len, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press(input bit u, input bit r, input bit d, input bit l);
    step(1'b0, g_run, g_len, u, r, d, l);
  endtask

  // Monitor: every cycle the DUT presents registered outputs; compare them
  // with the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({Tick, Dir, Queue_Level, Drop} !== e) begin
          miscompares++;
          $display("FAIL outputs @%0t: got tick=%b dir=%b level=%0d drop=%b, want tick=%b dir=%b level=%0d drop=%b",
                   $time, Tick, Dir, Queue_Level, Drop, e.tick, e.dir, e.level, e.drop);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    g_run = 1'b0; g_len = 0;
    rst_cycles(3);
    // Length 0: ticks every 20 cycles
    g_run = 1'b1; idle(65);
    // Length 15: underflow clamps to 4
    g_len = 15; idle(13);
    // Length 0 -> 8 mid-interval ends it immediately
    g_len = 0; rst_cycles(2); idle(11); g_len = 8; idle(6);
    // Up then Left queued, applied on successive ticks
    g_len = 0; rst_cycles(2); idle(3); press(1, 0, 0, 0); idle(2); press(0, 0, 0, 1); idle(45);
    // Opposite press dropped; Up+Down keeps Up and drops
    rst_cycles(2); idle(2); press(0, 0, 0, 1); idle(2); press(1, 0, 1, 0); idle(3);
    // Full queue drop, then push alongside the tick pop
    rst_cycles(2); idle(2); press(1, 0, 0, 0); idle(1); press(0, 0, 0, 1); idle(1);
    press(0, 0, 1, 0); idle(13); press(0, 0, 1, 0); idle(5);
    // Run drop flushes; reset mid-interval restarts timing
    g_run = 1'b0; idle(5);
    g_run = 1'b1; idle(13); rst_cycles(1); idle(25);
    // Randomized traffic
    repeat (3000) begin
      if ($urandom_range(0, 149) == 0) g_run = !g_run;
      if ($urandom_range(0, 39) == 0) g_len = int'($urandom_range(0, 15));
      step($urandom_range(0, 299) == 0, g_run, g_len,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
    end
    @(posedge Clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
